// File: rtl/pitch_detect.sv
// Nearest-note pitch classifier: scans 48 equal-tempered candidates (C3..B6) one per cycle.
// Optional PITCH_DETECT_EARLY_EXIT_EN stops the scan once candidate distances start growing.
module pitch_detect #(
    parameter int MIN_HZ = 127,
    parameter int MAX_HZ = 2033
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] freq,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  note,
    output logic [1:0]  octave,
    output logic        isValid,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [19:0] MIN_F = 20'(MIN_HZ);
    localparam logic [19:0] MAX_F = 20'(MAX_HZ);

    state_t      r_state;
    logic [19:0] r_freq;
    logic [3:0]  r_noteIdx;
    logic [1:0]  r_octIdx;
    logic [26:0] r_bestDist;
    logic [3:0]  r_bestNote;
    logic [1:0]  r_bestOct;
    logic        r_searchDone;

    logic [14:0] w_base;
    logic [26:0] w_cand;
    logic [26:0] w_freq100;
    logic [26:0] w_dist;
    logic        w_last;
    logic        w_stop;
    logic        w_inRange;

    // Octave-3 note frequencies scaled by 100; higher octaves are left shifts.
    always_comb begin
        w_base = 15'd0;
        case (r_noteIdx)
            4'd0:    w_base = 15'd13081;
            4'd1:    w_base = 15'd13859;
            4'd2:    w_base = 15'd14683;
            4'd3:    w_base = 15'd15556;
            4'd4:    w_base = 15'd16481;
            4'd5:    w_base = 15'd17461;
            4'd6:    w_base = 15'd18500;
            4'd7:    w_base = 15'd19600;
            4'd8:    w_base = 15'd20765;
            4'd9:    w_base = 15'd22000;
            4'd10:   w_base = 15'd23308;
            4'd11:   w_base = 15'd24694;
            default: w_base = 15'd0;
        endcase
    end

    assign w_cand    = 27'(w_base) << r_octIdx;
    assign w_freq100 = 27'(r_freq) * 27'd100;
    assign w_dist    = (w_freq100 >= w_cand) ? (w_freq100 - w_cand) : (w_cand - w_freq100);
    assign w_last    = (r_noteIdx == 4'd11) && (r_octIdx == 2'd3);
    assign w_inRange = (r_freq >= MIN_F) && (r_freq <= MAX_F);

`ifdef PITCH_DETECT_EARLY_EXIT_EN
    // Candidates rise monotonically, so a growing distance means the minimum is behind us.
    assign w_stop = w_last || (w_dist > r_bestDist);
`else
    assign w_stop = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_freq       <= 20'd0;
            r_noteIdx    <= 4'd0;
            r_octIdx     <= 2'd0;
            r_bestDist   <= '1;
            r_bestNote   <= 4'd0;
            r_bestOct    <= 2'd0;
            r_searchDone <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            note         <= 4'd0;
            octave       <= 2'd0;
            isValid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_freq       <= freq;
                        r_noteIdx    <= 4'd0;
                        r_octIdx     <= 2'd0;
                        r_bestDist   <= '1;
                        r_bestNote   <= 4'd0;
                        r_bestOct    <= 2'd0;
                        r_searchDone <= 1'b0;
                        in_ready     <= 1'b0;
                        r_state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    // One extra cycle after the last evaluation publishes the registered result.
                    if (r_searchDone) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        note      <= w_inRange ? r_bestNote : 4'd0;
                        octave    <= w_inRange ? r_bestOct : 2'd0;
                        isValid   <= w_inRange;
                    end else begin
                        if (w_dist < r_bestDist) begin
                            r_bestDist <= w_dist;
                            r_bestNote <= r_noteIdx;
                            r_bestOct  <= r_octIdx;
                        end
                        if (w_stop) begin
                            r_searchDone <= 1'b1;
                        end else if (r_noteIdx == 4'd11) begin
                            r_noteIdx <= 4'd0;
                            r_octIdx  <= r_octIdx + 2'd1;
                        end else begin
                            r_noteIdx <= r_noteIdx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
